// File: rtl/sha_round_ctrl.sv
// SHA-256 round controller: loads one 16-word message block through a
// valid/ready handshake, enables the external round counter until its flag
// marks the last round, pulses a digest update, then holds done until acked.
// Optional feature macro: ROUND_TIMEOUT_EN adds a RUN-state watchdog that
// aborts to DONE with o_err set if the counter flag never arrives.

module sha_round_ctrl #(
  parameter int unsigned MAX_CNT   = 63,
  parameter int unsigned CNT_SIZE  = 6,
  parameter int unsigned MSG_WORDS = 16,
  parameter int unsigned ADDR_W    = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_start,
  input  logic                i_msg_valid,
  output logic                o_msg_ready,
  output logic                o_wr_en,
  output logic [ADDR_W-1:0]   o_wr_addr,
  output logic                o_cnt_en,
  input  logic                i_flag,
  input  logic [CNT_SIZE-1:0] i_count,
  output logic                o_digest_upd,
  output logic                o_busy,
  output logic                o_done,
  input  logic                i_ack,
  output logic                o_err
);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StFinal, StDone} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MSG_WORDS - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                err_q;
  // High only on the first RUN cycle, when the counter must read zero.
  logic                first_q;

`ifdef ROUND_TIMEOUT_EN
  // Value held on the last permitted RUN cycle; the next increment would
  // reach MAX_CNT+4.
  localparam logic [CNT_SIZE:0] WdLast = (CNT_SIZE + 1)'(MAX_CNT + 3);
  logic [CNT_SIZE:0]   wd_q;
`endif

  // Controller state, load address, entry check and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
`ifdef ROUND_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (i_start) state_q <= StLoad;
        end
        StLoad: begin
          if (i_msg_valid) begin
            if (addr_q == LastAddr) begin
              addr_q  <= '0;
              first_q <= 1'b1;
              state_q <= StRun;
`ifdef ROUND_TIMEOUT_EN
              wd_q    <= '0;
`endif
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        StRun: begin
          first_q <= 1'b0;
          if (first_q && (i_count != '0)) err_q <= 1'b1;
`ifdef ROUND_TIMEOUT_EN
          wd_q <= wd_q + 1'b1;
          if (i_flag) begin
            state_q <= StFinal;
          end else if (wd_q == WdLast) begin
            err_q   <= 1'b1;
            state_q <= StDone;
          end
`else
          if (i_flag) state_q <= StFinal;
`endif
        end
        StFinal: begin
          state_q <= StDone;
        end
        StDone: begin
          if (i_ack) state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
      // The counter can only legitimately hit its last value while enabled.
      if (i_flag && (state_q != StRun)) err_q <= 1'b1;
    end
  end

  // Moore outputs decoded from registered state; the write strobe alone
  // follows i_msg_valid combinationally.
  always_comb begin
    o_msg_ready  = (state_q == StLoad);
    o_wr_en      = i_msg_valid & o_msg_ready;
    o_wr_addr    = addr_q;
    o_cnt_en     = (state_q == StRun);
    o_digest_upd = (state_q == StFinal);
    o_busy       = (state_q != StIdle);
    o_done       = (state_q == StDone);
    o_err        = err_q;
  end

endmodule

// File: tb/tb_sha_round_ctrl.sv
// Self-checking bench for sha_round_ctrl with a behavioural round counter
// (MAX_CNT = 63) attached to the enable/flag/count interface.
// Build with ROUND_TIMEOUT_EN defined to also exercise the watchdog.

module tb_sha_round_ctrl;

  localparam int MaxCnt = 63;

  logic       clk;
  logic       reset_n;
  logic       i_start, i_msg_valid, i_ack;
  logic       o_msg_ready, o_wr_en, o_cnt_en, o_digest_upd, o_busy, o_done, o_err;
  logic [3:0] o_wr_addr;
  logic [5:0] cnt;
  logic       flag, flag_inj, flag_mask;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int en_total = 0;
  int dig_total = 0;
  int wr_total = 0;
  int t0 = 0;

  sha_round_ctrl #(
    .MAX_CNT  (63),
    .CNT_SIZE (6),
    .MSG_WORDS(16),
    .ADDR_W   (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_start     (i_start),
    .i_msg_valid (i_msg_valid),
    .o_msg_ready (o_msg_ready),
    .o_wr_en     (o_wr_en),
    .o_wr_addr   (o_wr_addr),
    .o_cnt_en    (o_cnt_en),
    .i_flag      (flag),
    .i_count     (cnt),
    .o_digest_upd(o_digest_upd),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .i_ack       (i_ack),
    .o_err       (o_err)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Round counter model sharing the controller's reset.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else if (o_cnt_en) cnt <= (cnt == 6'(MaxCnt)) ? 6'd0 : cnt + 6'd1;
  end
  assign flag = ((cnt == 6'(MaxCnt)) && !flag_mask) || flag_inj;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n && o_cnt_en) en_total = en_total + 1;
    if (reset_n && o_digest_upd) dig_total = dig_total + 1;
    if (reset_n && o_wr_en) wr_total = wr_total + 1;
  end

  typedef struct {
    logic       start;
    logic       valid;
    logic       ready;
    logic       wr_en;
    logic [3:0] addr;
    logic       busy;
    logic       cnt_en;
  } vec_t;

  vec_t tv[21];

  function automatic vec_t mk(logic s, logic v, logic r, logic w, logic [3:0] a,
                              logic b, logic c);
    vec_t x;
    x.start = s; x.valid = v; x.ready = r; x.wr_en = w; x.addr = a; x.busy = b;
    x.cnt_en = c;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] all_outs();
    return {20'd0, o_msg_ready, o_wr_en, o_cnt_en, o_digest_upd, o_busy, o_done, o_err,
            1'b0, o_wr_addr};
  endfunction

  // Wait for o_done; elapsed counts edges from the start-sampling edge inclusive.
  task automatic wait_done(input int budget, output int elapsed);
    elapsed = -1;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #1;
      if (o_done) begin
        elapsed = cyc - t0 + 1;
        break;
      end
    end
    if (elapsed < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  // Start a block and stream 16 back-to-back words.
  task automatic load_block();
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    i_start = 1'b0;
    i_msg_valid = 1'b1;
    repeat (16) @(posedge clk);
    @(negedge clk);
    i_msg_valid = 1'b0;
  endtask

  task automatic ack_block();
    @(negedge clk);
    i_ack = 1'b1;
    @(posedge clk);
    #1;
    check("ack_to_idle", {30'd0, o_done, o_busy}, 32'd0);
    @(negedge clk);
    i_ack = 1'b0;
  endtask

  initial begin
    int el, en0, dig0, wr0;
    logic held;
    reset_n = 1'b0; i_start = 0; i_msg_valid = 0; i_ack = 0; flag_inj = 0; flag_mask = 0;

    tv[0] = mk(1, 0, 0, 0, 4'd0, 0, 0);
    for (int i = 1; i <= 6; i++) tv[i] = mk(0, 1, 1, 1, 4'(i - 1), 1, 0);
    for (int i = 7; i <= 9; i++) tv[i] = mk(0, 0, 1, 0, 4'd6, 1, 0);
    for (int i = 10; i <= 19; i++) tv[i] = mk(0, 1, 1, 1, 4'(i - 4), 1, 0);
    tv[20] = mk(1, 1, 0, 0, 4'd0, 1, 1);

    // Reset and sticky error from a stray flag in IDLE.
    #15 reset_n = 1'b1;
    #1 check("reset_outs", all_outs(), 32'd0);
    @(negedge clk);
    flag_inj = 1'b1;
    @(negedge clk);
    flag_inj = 1'b0;
    #1 check("idle_flag_err", {31'd0, o_err}, 32'd1);
    @(negedge clk);
    check("err_sticky", {31'd0, o_err}, 32'd1);
    reset_n = 1'b0;
    #1 check("reset_clears_err", all_outs(), 32'd0);
    #9 reset_n = 1'b1;

    // Block 1 via vector table: load with a 3-cycle stall after word 5.
    en0 = en_total; dig0 = dig_total; wr0 = wr_total;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      i_start = tv[i].start;
      i_msg_valid = tv[i].valid;
      #1;
      check($sformatf("vec%0d", i),
            {24'd0, o_msg_ready, o_wr_en, o_wr_addr, o_busy, o_cnt_en},
            {24'd0, tv[i].ready, tv[i].wr_en, tv[i].addr, tv[i].busy, tv[i].cnt_en});
      if (i == 0) begin
        @(posedge clk);
        #1 t0 = cyc;
      end
    end
    @(negedge clk);
    i_start = 1'b0; i_msg_valid = 1'b0;
    wait_done(300, el);
    check("stall_latency", el, 32'd85);
    check("stall_cnt_en", en_total - en0, 32'd64);
    check("stall_digest", dig_total - dig0, 32'd1);
    check("stall_writes", wr_total - wr0, 32'd16);
    check("stall_err", {31'd0, o_err}, 32'd0);

    // Done held without ack, ack held two cycles.
    held = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!(o_done && o_busy)) held = 1'b0;
    end
    check("done_held", {31'd0, held}, 32'd1);
    @(negedge clk);
    i_ack = 1'b1;
    @(posedge clk);
    #1 check("ack_idle", {30'd0, o_done, o_busy}, 32'd0);
    @(posedge clk);
    #1 check("ack_held_idle", {30'd0, o_done, o_busy}, 32'd0);
    @(negedge clk);
    i_ack = 1'b0;

    // Block 2: back-to-back words, minimum latency.
    check("blk2_count0", {26'd0, cnt}, 32'd0);
    en0 = en_total; dig0 = dig_total;
    load_block();
    wait_done(300, el);
    check("blk2_latency", el, 32'd82);
    check("blk2_cnt_en", en_total - en0, 32'd64);
    check("blk2_digest", dig_total - dig0, 32'd1);
    check("blk2_err", {31'd0, o_err}, 32'd0);
    check("blk2_cnt_wrap", {26'd0, cnt}, 32'd0);
    ack_block();

    // Reset in the middle of RUN.
    load_block();
    el = 0;
    while (cnt != 6'd30 && el < 100) begin
      @(negedge clk);
      el++;
    end
    check("reached_cnt30", {26'd0, cnt}, 32'd30);
    reset_n = 1'b0;
    #1 check("midrun_reset_outs", all_outs(), 32'd0);
    check("midrun_reset_cnt", {26'd0, cnt}, 32'd0);
    #10 reset_n = 1'b1;
    en0 = en_total; dig0 = dig_total;
    load_block();
    wait_done(300, el);
    check("blk3_latency", el, 32'd82);
    check("blk3_cnt_en", en_total - en0, 32'd64);
    check("blk3_digest", dig_total - dig0, 32'd1);
    check("blk3_err", {31'd0, o_err}, 32'd0);
    ack_block();

`ifdef ROUND_TIMEOUT_EN
    // Watchdog: flag never arrives.
    flag_mask = 1'b1;
    en0 = en_total; dig0 = dig_total;
    load_block();
    wait_done(300, el);
    check("wd_latency", el, 32'd84);
    check("wd_run_cycles", en_total - en0, 32'd67);
    check("wd_no_digest", dig_total - dig0, 32'd0);
    check("wd_err", {31'd0, o_err}, 32'd1);
    flag_mask = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/sha_round_ctrl.md
Name: sha_round_ctrl

Overview:
- Control unit for the SHA-256 datapath and the initiator side of the round counter's enable/flag interface.
- Loads one 16-word message block into the schedule buffer through a valid/ready handshake.
- Drives the round counter's enable until its flag reports the last round, then issues a digest update and holds done until acknowledged.

Parameters:
MAX_CNT, 63, last round index; must match the round counter's MAX_CNT
CNT_SIZE, 6, round counter width
MSG_WORDS, 16, words per message block
ADDR_W, 4, message write address width (log2 MSG_WORDS)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
i_start  input  1  begin one block; sampled only in IDLE
i_msg_valid  input  1  message word present on the external bus
o_msg_ready  output  1  controller accepts a message word this cycle
o_wr_en  output  1  message buffer write strobe (= i_msg_valid & o_msg_ready)
o_wr_addr  output  ADDR_W  message buffer write address
o_cnt_en  output  1  enable to round counter
i_flag  input  1  round counter flag, high while count == MAX_CNT
i_count  input  CNT_SIZE  round counter value, used for the entry check only
o_digest_upd  output  1  one-cycle pulse: add working vars into hash
o_busy  output  1  high in every state except IDLE
o_done  output  1  block complete, held until i_ack
i_ack  input  1  host acknowledge of o_done
o_err  output  1  sticky protocol error flag

Behaviour:
- Reset: state=IDLE, o_wr_addr=0, o_err=0, load counter=0. All strobes, o_busy and o_done read 0. Reset asserted mid-operation aborts to IDLE immediately. The round counter is reset by the same reset_n.
- All outputs except o_wr_en are Moore-decoded from registered state and counters. o_wr_en is combinational.
- States: IDLE, LOAD, RUN, FINAL, DONE.
- IDLE to LOAD on i_start=1. i_start in any other state is ignored.
- LOAD:
  - o_msg_ready=1 and o_wr_addr = load counter.
  - A word is accepted when i_msg_valid & o_msg_ready. The load counter then increments.
  - With i_msg_valid=0 the controller stalls indefinitely; the address is held.
  - On accepting the word at address MSG_WORDS-1, the counter wraps to 0 and the next state is RUN.
- RUN:
  - o_cnt_en=1.
  - On the first RUN cycle i_count must equal 0. If it does not, set o_err=1 and continue.
  - While i_flag=0, stay in RUN.
  - When i_flag=1, the next state is FINAL. The enable on that same cycle makes the counter wrap to 0, ready for the next block.
  - RUN therefore lasts exactly MAX_CNT+1 cycles.
- FINAL: o_digest_upd=1 for exactly one cycle, o_cnt_en=0, then DONE.
- DONE:
  - o_done=1 and o_busy=1.
  - i_ack=1 moves to IDLE. i_ack held across multiple cycles has no further effect.
  - i_ack outside DONE is ignored.
- i_flag=1 outside RUN sets o_err=1. o_err clears only on reset.
- Latency: from accepted i_start, 1 cycle to LOAD, then 16 handshake beats, then 64 RUN cycles, then 1 FINAL cycle before o_done. The minimum is 82 cycles from start accept to o_done=1.

Optional Feature:
- Macro: ROUND_TIMEOUT_EN.
- Defined:
  - An internal watchdog of CNT_SIZE+1 bits clears on RUN entry and increments each RUN cycle.
  - If it reaches MAX_CNT+4 without i_flag, set o_err=1 and go to DONE without pulsing o_digest_upd.
- Undefined: no watchdog; RUN waits for i_flag forever.

Test Plan:
- Reset with reset_n=0 for 15 ns, then release -> all outputs 0 and state IDLE. i_flag pulsed in IDLE -> o_err=1.
- i_start=1, 16 back-to-back valid words 0x00..0x0F, counter connected with MAX_CNT=63 -> o_wr_addr 0..15 with o_wr_en each cycle; o_cnt_en high for exactly 64 cycles; one o_digest_upd pulse; o_done=1 at cycle 82 after start.
- Valid stalls: i_msg_valid low for 3 cycles after word 5 -> o_wr_addr holds 6 and no o_wr_en; completion is delayed by exactly 3 cycles.
- o_done held with i_ack low for 10 cycles, then i_ack=1 -> o_done stays 1 until ack, back to IDLE. A second block starts with i_count=0 and o_err=0.
- reset_n=0 during RUN at count 30 -> all outputs immediately 0. The next block completes normally.
- With ROUND_TIMEOUT_EN, i_flag tied low -> after 67 RUN cycles o_err=1, DONE reached, no o_digest_upd pulse.
